// File: rtl/bit_stream_gen_if.sv
// Port bundle for bit_stream_gen: start request and pattern in, serial bit stream and status out.
// master is the generator side and slave is the stimulus or detector side.
interface bit_stream_gen_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] bit_idx;

    // x_valid is a one-cycle strobe. The consumer samples x exactly once per strobe.
    // There is no back-pressure path.
    modport master (
        input  start, pattern,
        output x, x_valid, busy, done, bit_idx
    );

    modport slave (
        output start, pattern,
        input  x, x_valid, busy, done, bit_idx
    );
endinterface

// File: rtl/bit_stream_gen.sv
// Serial pattern source: captures a parallel pattern on a start edge and shifts it out MSB first, one bit per DIV clocks.
// Optional repeat mode is enabled by defining BITGEN_LOOP_EN.
module bit_stream_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 50_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    bit_stream_gen_if.master        bus,
    output logic [1:0]              dbg_state_o
);
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic             sync1_q, sync2_q, sync3_q;
    logic             start_pulse;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef BITGEN_LOOP_EN
    logic             stop_q, stop_d;
`endif

    // Two flops for metastability, then a third copy used only for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= bus.start;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign start_pulse = sync2_q & ~sync3_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifdef BITGEN_LOOP_EN
        stop_d  = stop_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef BITGEN_LOOP_EN
                stop_d = 1'b0;
`endif
                if (start_pulse) state_d = S_LOAD;
            end
            S_LOAD: begin
                shreg_d = bus.pattern;
                idx_d   = '0;
                cnt_d   = '0;
                state_d = S_SHIFT;
`ifdef BITGEN_LOOP_EN
                if (start_pulse) stop_d = 1'b1;
`endif
            end
            S_SHIFT: begin
`ifdef BITGEN_LOOP_EN
                if (start_pulse) stop_d = 1'b1;
`endif
                if (cnt_q == CNT_MAX) begin
`ifdef BITGEN_LOOP_EN
                    // A stop request always lets the current bit period complete.
                    if (stop_d) begin
                        state_d = S_DONE;
                    end else if (idx_q == IDX_MAX) begin
                        state_d = S_LOAD;
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = '0;
                    end
`else
                    if (idx_q == IDX_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = '0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
`ifdef BITGEN_LOOP_EN
                stop_d = 1'b0;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
`ifdef BITGEN_LOOP_EN
            stop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
`ifdef BITGEN_LOOP_EN
            stop_q  <= stop_d;
`endif
        end
    end

    // Outputs decode straight from state so the asynchronous reset clears them immediately.
    assign bus.x       = (state_q == S_SHIFT) & shreg_q[WIDTH-1];
    assign bus.x_valid = (state_q == S_SHIFT) && (cnt_q == '0);
    assign bus.busy    = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign bus.done    = (state_q == S_DONE);
    assign bus.bit_idx = idx_q;
    assign dbg_state_o = state_q;
endmodule
